// File: rtl/life_gen_sequencer.sv
// Computes one Game-of-Life generation over a 32x32 torus in a double-banked cell RAM.
// Optional LIFE_RULE_CFG_EN adds birth_mask/survive_mask rule inputs (default: fixed B3/S23).
module life_gen_sequencer #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned GEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_req,
  input  logic             pause,
`ifdef LIFE_RULE_CFG_EN
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
`endif
  output logic [10:0]      mem_rd_addr,
  input  logic             mem_rd_data,
  output logic             mem_we,
  output logic [10:0]      mem_wr_addr,
  output logic             mem_wr_data,
  output logic             cur_bank,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;

  // Per-cell timeline: issue at t=0..8, sample at t=RD_LAT..8+RD_LAT, write at t=9+RD_LAT.
  localparam logic [3:0] T_S0 = 4'(RD_LAT);
  localparam logic [3:0] T_S8 = 4'(RD_LAT + 8);
  localparam logic [3:0] T_WR = 4'(RD_LAT + 9);

  logic [1:0]       state_q, state_d;
  logic [4:0]       x_q, x_d, y_q, y_d;
  logic [3:0]       t_q, t_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             self_q, self_d;
  logic             pending_q, pending_d;
  logic             bank_q, bank_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic [10:0]      rd_addr_q, rd_addr_d;
  logic [10:0]      wr_addr_q, wr_addr_d;
  logic             wr_data_q, wr_data_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [3:0]       k_c;
  logic             sample_c;
`ifdef LIFE_RULE_CFG_EN
  logic [8:0]       birth_q, birth_d, surv_q, surv_d;
`endif

  // Address of neighbour k (row-major over the 3x3 window) with mod-32 wrap.
  function automatic logic [10:0] nb_addr(input logic bank, input logic [4:0] x,
                                          input logic [4:0] y, input logic [3:0] k);
    logic [4:0] xo, yo;
    case (k)
      4'd0, 4'd3, 4'd6: xo = x - 5'd1;
      4'd1, 4'd4, 4'd7: xo = x;
      default:          xo = x + 5'd1;
    endcase
    case (k)
      4'd0, 4'd1, 4'd2: yo = y - 5'd1;
      4'd3, 4'd4, 4'd5: yo = y;
      default:          yo = y + 5'd1;
    endcase
    return {bank, yo, xo};
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    self_d    = self_q;
    pending_d = pending_q | step_req;
    bank_d    = bank_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    gen_d     = gen_q;
`ifdef LIFE_RULE_CFG_EN
    birth_d   = birth_q;
    surv_d    = surv_q;
`endif
    k_c       = t_q - T_S0;
    sample_c  = (t_q >= T_S0) && (t_q <= T_S8);

    case (state_q)
      S_IDLE: begin
        if ((pending_q | step_req) && !pause) begin
          state_d   = S_RUN;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          x_d       = 5'd0;
          y_d       = 5'd0;
          t_d       = 4'd0;
          cnt_d     = 4'd0;
          self_d    = 1'b0;
          rd_addr_d = nb_addr(bank_q, 5'd0, 5'd0, 4'd0);
`ifdef LIFE_RULE_CFG_EN
          birth_d   = birth_mask;
          surv_d    = survive_mask;
`endif
        end
      end
      S_RUN: begin
        if (sample_c) begin
          if (k_c == 4'd4) self_d = mem_rd_data;
          else             cnt_d  = cnt_q + 4'(mem_rd_data);
        end
        if (t_q == T_WR) begin
          cnt_d  = 4'd0;
          self_d = 1'b0;
          t_d    = 4'd0;
          if (x_q == 5'd31 && y_q == 5'd31) begin
            state_d = S_SWAP;
            done_d  = 1'b1;
          end else begin
            x_d = x_q + 5'd1;
            if (x_q == 5'd31) y_d = y_q + 5'd1;
            rd_addr_d = nb_addr(bank_q, x_d, y_d, 4'd0);
          end
        end else begin
          t_d = t_q + 4'd1;
          if (t_d <= 4'd8) rd_addr_d = nb_addr(bank_q, x_q, y_q, t_d);
          // Count is complete once the k=8 sample lands, so the write data is known here.
          if (t_d == T_WR) begin
            we_d      = 1'b1;
            wr_addr_d = {~bank_q, y_q, x_q};
`ifdef LIFE_RULE_CFG_EN
            wr_data_d = self_d ? surv_q[cnt_d] : birth_q[cnt_d];
`else
            wr_data_d = (cnt_d == 4'd3) | (self_d & (cnt_d == 4'd2));
`endif
          end
        end
      end
      S_SWAP: begin
        bank_d  = ~bank_q;
        gen_d   = gen_q + GEN_W'(1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= 5'd0;
      y_q       <= 5'd0;
      t_q       <= 4'd0;
      cnt_q     <= 4'd0;
      self_q    <= 1'b0;
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      rd_addr_q <= 11'd0;
      wr_addr_q <= 11'd0;
      wr_data_q <= 1'b0;
      gen_q     <= '0;
`ifdef LIFE_RULE_CFG_EN
      birth_q   <= 9'd0;
      surv_q    <= 9'd0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      self_q    <= self_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      gen_q     <= gen_d;
`ifdef LIFE_RULE_CFG_EN
      birth_q   <= birth_d;
      surv_q    <= surv_d;
`endif
    end
  end

  assign mem_rd_addr = rd_addr_q;
  assign mem_we      = we_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign cur_bank    = bank_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign gen_count   = gen_q;

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
Sequences one Game-of-Life generation over the 32x32 toroidal cell grid held in an external double-banked 1-bit cell RAM (2 x 1024 entries).
- Reads the 3x3 neighbourhood of each cell from the display bank and computes the next state.
- Writes the result into the shadow bank, then swaps banks.
- Sits between the step/pause controls and the cell RAM. The VGA scan path reads cur_bank and feeds color_generator.

Parameters:
RD_LAT, 1, cell RAM read latency in cycles (1..3); mem_rd_data is valid RD_LAT cycles after mem_rd_addr.
GEN_W, 16, width of the generation counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
step_req  in  1  single-cycle request to compute one generation
pause  in  1  level; while high, no new generation is started
mem_rd_addr  out  11  {bank, y[4:0], x[4:0]}; bank is always cur_bank
mem_rd_data  in  1  cell state returned RD_LAT cycles after the address
mem_we  out  1  write strobe for the shadow bank
mem_wr_addr  out  11  {~cur_bank, y, x}
mem_wr_data  out  1  next state of cell (x,y)
cur_bank  out  1  bank being displayed and read
busy  out  1  high while a generation is in progress
done  out  1  one-cycle pulse in the SWAP cycle
gen_count  out  GEN_W  number of completed generations; wraps mod 2^GEN_W

Behaviour:
- Reset (async): state=IDLE; cur_bank=0; busy=0; done=0; mem_we=0; mem_rd_addr=0; mem_wr_addr=0; mem_wr_data=0; gen_count=0; pending=0; x=y=0; neighbour count=0.
- Reset mid-generation abandons the partial shadow bank. The abandoned data is harmless because cur_bank is unchanged (0).
- pending flag:
  - Set by step_req in any state.
  - Cleared when a generation starts.
  - One deep: extra requests while pending=1 are dropped.
- IDLE: if (pending or step_req) and !pause, go to RUN at this edge, with busy=1 in the next cycle and x=y=0.
- RUN (per cell, t=0 at the first issue cycle):
  - Cycles t=0..8 issue neighbour k=t. k order: (x-1,y-1), (x,y-1), (x+1,y-1), (x-1,y), (x,y), (x+1,y), (x-1,y+1), (x,y+1), (x+1,y+1).
  - All coordinate arithmetic is 5-bit mod 32 (torus wrap, no edge special case).
  - Data for k is sampled at t=k+RD_LAT. k=4 is latched as self; the others add to a 4-bit count (0..8).
  - Cycle t=9+RD_LAT is the WRITE cycle:
    - mem_we=1 for exactly this one cycle.
    - mem_wr_data = (count==3) | (self & count==2).
  - Count and self clear at the end of the WRITE cycle.
  - The next cell issues at the following cycle.
  - Each cell takes exactly 10+RD_LAT cycles. Scan order is x fastest, then y.
- After the WRITE of (31,31), go to SWAP:
  - done=1 for this cycle.
  - cur_bank toggles and gen_count increments at the end of this cycle.
  - Then return to IDLE; busy=0 from the next cycle.
- Generation latency: from the first issue cycle to the SWAP cycle inclusive, 1024*(10+RD_LAT)+1 cycles. With RD_LAT=1 this is 11265 cycles.
- pause does not interrupt a running generation. It only gates the start from IDLE.
- step_req in the SWAP cycle sets pending, so the next generation starts immediately after IDLE is entered (unless paused).
- mem_rd_addr holds its last value when not issuing. mem_we is 0 outside the WRITE cycle.

Optional Feature:
LIFE_RULE_CFG_EN
- Defined: adds input ports birth_mask[8:0] and survive_mask[8:0].
  - next = self ? survive_mask[count] : birth_mask[count].
  - Masks are sampled once at generation start and held for the whole generation.
- Undefined: fixed rule B3/S23 as specified above; no extra ports.

Test Plan:
1. Horizontal blinker at (10..12,5), RD_LAT=1, one step_req → done after 11265 cycles; cur_bank=1; bank1 holds a vertical blinker at (11,4..6) and all other cells 0; gen_count=1.
2. Glider at x=30..31/0, y=30..31/0 (spanning the torus edge), 4 steps → the glider is translated by (+1,+1) mod 32 with its shape intact; gen_count=4; cur_bank=0.
3. step_req pulsed twice during one busy generation, then once in the SWAP cycle → exactly 2 generations run back-to-back; the second starts with a single IDLE cycle between them; gen_count=2.
4. pause=1 with step_req pulsed → stays IDLE, busy=0. Release pause after 100 cycles → the generation starts on the release edge.
5. Assert rst at cycle 5000 of a generation → all outputs return to reset values immediately; cur_bank=0; bank0 is unchanged by the abandoned generation.
6. RD_LAT=3 with an empty grid → per-cell mem_we spacing is 13 cycles; done arrives after 13313 cycles; all writes carry 0. With LIFE_RULE_CFG_EN and birth_mask=9'h001, every cell is written 1.
